fir_controller: RTL

Sequencing FSM for the FIR filter datapath. On each new sample it shifts the four-tap sample history and runs four multiply/accumulate steps with alternating add/subtract into the accumulator. It also services coefficient-load pulses from `coefficient_loader`, queueing one pulse that arrives while a computation is in flight. It drives the datapath opcode and register-select lines and the `modwait` busy flag back to the bus interface and `coefficient_loader`.

---
 rtl/fir_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fir_controller.sv
// Sequencing FSM for the four-tap FIR datapath: sample shift, alternating MAC,
// and queued coefficient loads. All outputs are registered Moore decodes.
module fir_controller (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       dr,
    input  logic       lc,
    input  logic [1:0] coefficient_num,
    input  logic       overflow,
    output logic       cnt_up,
    output logic       modwait,
    output logic       err,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest
);

    typedef enum logic [4:0] {
        IDLE, EIDLE, LOADF, STORE, ZERO,
        SORT1, SORT2, SORT3, SORT4,
        MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_COPY  = 3'b001,
        OP_LOAD1 = 3'b010,
        OP_LOAD2 = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_MUL   = 3'b110
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [3:0] src1;
        logic [3:0] src2;
        logic [3:0] dest;
        logic       cnt_up;
        logic       modwait;
        logic       err;
    } ctrl_t;

    state_t     state_q, state_d;
    logic       pend_q, pend_d;
    logic [1:0] coeff_sel_q, coeff_sel_d;
    ctrl_t      ctrl_q;

    function automatic ctrl_t set_op(op_t o, logic [3:0] s1, logic [3:0] s2, logic [3:0] d);
        ctrl_t c;
        c         = '0;
        c.modwait = 1'b1;
        c.op      = o;
        c.src1    = s1;
        c.src2    = s2;
        c.dest    = d;
        return c;
    endfunction

    function automatic ctrl_t decode(state_t s, logic [1:0] sel);
        ctrl_t c;
        c = set_op(OP_NOP, 4'd0, 4'd0, 4'd0);
        case (s)
            IDLE:  c.modwait = 1'b0;
            EIDLE: begin
                c.modwait = 1'b0;
                c.err     = 1'b1;
            end
            LOADF: c = set_op(OP_LOAD2, 4'd0, 4'd0, 4'd6 + {2'b00, sel});
            STORE: c = set_op(OP_LOAD1, 4'd0, 4'd0, 4'd1);
            ZERO:  begin
                c        = set_op(OP_SUB, 4'd0, 4'd0, 4'd0);
                c.cnt_up = 1'b1;
            end
            SORT1: c = set_op(OP_COPY, 4'd4, 4'd0, 4'd5);
            SORT2: c = set_op(OP_COPY, 4'd3, 4'd0, 4'd4);
            SORT3: c = set_op(OP_COPY, 4'd2, 4'd0, 4'd3);
            SORT4: c = set_op(OP_COPY, 4'd1, 4'd0, 4'd2);
            MUL1:  c = set_op(OP_MUL, 4'd2, 4'd6, 4'd10);
            ADD1:  c = set_op(OP_ADD, 4'd0, 4'd10, 4'd0);
            MUL2:  c = set_op(OP_MUL, 4'd3, 4'd7, 4'd10);
            SUB2:  c = set_op(OP_SUB, 4'd0, 4'd10, 4'd0);
            MUL3:  c = set_op(OP_MUL, 4'd4, 4'd8, 4'd10);
            ADD3:  c = set_op(OP_ADD, 4'd0, 4'd10, 4'd0);
            MUL4:  c = set_op(OP_MUL, 4'd5, 4'd9, 4'd10);
            SUB4:  c = set_op(OP_SUB, 4'd0, 4'd10, 4'd0);
            default: c.modwait = 1'b0;
        endcase
        return c;
    endfunction

    // A pulse arriving in LOADF re-arms pend, so the clear loses to lc.
    always_comb begin
        coeff_sel_d = lc ? coefficient_num : coeff_sel_q;
        pend_d      = lc | (pend_q & (state_q != LOADF));
        state_d     = state_q;
        case (state_q)
            IDLE, EIDLE: begin
                if (lc || pend_q) state_d = LOADF;
                else if (dr)      state_d = STORE;
            end
            LOADF: state_d = pend_d ? LOADF : IDLE;
            STORE: state_d = dr ? ZERO : EIDLE;
            ZERO:  state_d = SORT1;
            SORT1: state_d = SORT2;
            SORT2: state_d = SORT3;
            SORT3: state_d = SORT4;
            SORT4: state_d = MUL1;
            MUL1:  state_d = ADD1;
            ADD1:  state_d = overflow ? EIDLE : MUL2;
            MUL2:  state_d = SUB2;
            SUB2:  state_d = overflow ? EIDLE : MUL3;
            MUL3:  state_d = ADD3;
            ADD3:  state_d = overflow ? EIDLE : MUL4;
            MUL4:  state_d = SUB4;
            SUB4: begin
                if (overflow)          state_d = EIDLE;
                else if (pend_q || lc) state_d = LOADF;
                else                   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: outputs are decoded from the next state and registered, so they
    // line up with state_q cycle-for-cycle without a combinational output path.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            coeff_sel_q <= 2'd0;
            ctrl_q      <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            coeff_sel_q <= coeff_sel_d;
            ctrl_q      <= decode(state_d, coeff_sel_d);
        end
    end

    assign op      = ctrl_q.op;
    assign src1    = ctrl_q.src1;
    assign src2    = ctrl_q.src2;
    assign dest    = ctrl_q.dest;
    assign cnt_up  = ctrl_q.cnt_up;
    assign modwait = ctrl_q.modwait;
    assign err     = ctrl_q.err;

endmodule
